// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back, write-allocate cache datapath.
// Drives all datapath strobes and keeps saturating perf counters.
module cache_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             hit0,
    input  logic             hit1,
    input  logic             valid_bit,
    input  logic             dirty_bit,
    input  logic             lru_out,
    output logic             read_array,
    output logic             write_array,
    output logic             lru_load,
    output logic             data_select,
    output logic             dirty_select,
    output logic             pmem_select,
    output logic [1:0]       write0_select,
    output logic [1:0]       write1_select,
    output logic             valid_load0,
    output logic             valid_load1,
    output logic             tag_load0,
    output logic             tag_load1,
    output logic             dirty_load0,
    output logic             dirty_load1,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] COMPARE   = 2'd1;
    localparam logic [1:0] WRITEBACK = 2'd2;
    localparam logic [1:0] ALLOCATE  = 2'd3;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       relookup;
    logic       req;
    logic       hit;
    logic       hit_way;
    logic       inc_hit;
    logic       inc_miss;
    logic       inc_wb;

    assign req     = mem_read | mem_write;
    assign hit     = hit0 | hit1;
    // way0 takes precedence so only one way is ever strobed
    assign hit_way = ~hit0;

    assign inc_hit  = (state == COMPARE) & req & hit & ~relookup;
    assign inc_miss = (state == COMPARE) & req & ~hit;
    assign inc_wb   = (state == WRITEBACK) & pmem_resp;

    // Strobe decode and next state; everything held low during reset
    always_comb begin
        state_next    = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        read_array    = 1'b0;
        write_array   = 1'b0;
        lru_load      = 1'b0;
        data_select   = 1'b0;
        dirty_select  = 1'b0;
        pmem_select   = 1'b0;
        write0_select = 2'd0;
        write1_select = 2'd0;
        valid_load0   = 1'b0;
        valid_load1   = 1'b0;
        tag_load0     = 1'b0;
        tag_load1     = 1'b0;
        dirty_load0   = 1'b0;
        dirty_load1   = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    read_array  = mem_read & ~mem_write;
                    write_array = mem_write;
                    if (req)
                        state_next = COMPARE;
                end
                COMPARE: begin
                    if (!req) begin
                        state_next = IDLE;
                    end else if (hit) begin
                        mem_resp   = 1'b1;
                        lru_load   = 1'b1;
                        state_next = IDLE;
                        if (mem_write) begin
                            dirty_select = 1'b1;
                            if (hit_way) begin
                                write1_select = 2'd1;
                                dirty_load1   = 1'b1;
                            end else begin
                                write0_select = 2'd1;
                                dirty_load0   = 1'b1;
                            end
                        end
                    end else if (valid_bit & dirty_bit) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    if (pmem_resp) begin
                        if (lru_out)
                            dirty_load1 = 1'b1;
                        else
                            dirty_load0 = 1'b1;
                        state_next = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    pmem_read   = 1'b1;
                    pmem_select = 1'b1;
                    data_select = 1'b1;
                    if (pmem_resp) begin
                        if (lru_out) begin
                            write1_select = 2'd2;
                            tag_load1     = 1'b1;
                            valid_load1   = 1'b1;
                            dirty_load1   = 1'b1;
                        end else begin
                            write0_select = 2'd2;
                            tag_load0     = 1'b1;
                            valid_load0   = 1'b1;
                            dirty_load0   = 1'b1;
                        end
                        state_next = COMPARE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register; relookup marks the COMPARE that follows a fill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            relookup <= 1'b0;
        end else begin
            state    <= state_next;
            relookup <= (state == ALLOCATE) & pmem_resp;
        end
    end

    // Saturating perf counters; clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else if (perf_clr) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (inc_hit && hit_count != '1)
                hit_count <= hit_count + ONE;
            if (inc_miss && miss_count != '1)
                miss_count <= miss_count + ONE;
            if (inc_wb && wb_count != '1)
                wb_count <= wb_count + ONE;
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Randomized transaction-level bench for cache_control.
// Expected strobes come from a per-request cycle timeline.
module tb_cache_control;

    localparam int CW = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write, mem_resp;
    logic          pmem_resp, pmem_read, pmem_write;
    logic          hit0, hit1, valid_bit, dirty_bit, lru_out;
    logic          read_array, write_array, lru_load;
    logic          data_select, dirty_select, pmem_select;
    logic [1:0]    write0_select, write1_select;
    logic          valid_load0, valid_load1;
    logic          tag_load0, tag_load1;
    logic          dirty_load0, dirty_load1;
    logic          perf_clr;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    int total = 0;
    int bad = 0;
    int hc = 0;
    int mc = 0;
    int wc = 0;

    logic [18:0] obs;

    cache_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .hit0(hit0), .hit1(hit1), .valid_bit(valid_bit), .dirty_bit(dirty_bit),
        .lru_out(lru_out), .read_array(read_array), .write_array(write_array),
        .lru_load(lru_load), .data_select(data_select),
        .dirty_select(dirty_select), .pmem_select(pmem_select),
        .write0_select(write0_select), .write1_select(write1_select),
        .valid_load0(valid_load0), .valid_load1(valid_load1),
        .tag_load0(tag_load0), .tag_load1(tag_load1),
        .dirty_load0(dirty_load0), .dirty_load1(dirty_load1),
        .perf_clr(perf_clr), .hit_count(hit_count),
        .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    assign obs = {mem_resp, pmem_read, pmem_write, read_array, write_array,
                  lru_load, data_select, dirty_select, pmem_select,
                  write0_select, write1_select, valid_load0, valid_load1,
                  tag_load0, tag_load1, dirty_load0, dirty_load1};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic check_cnt(input string tag);
        check({tag, "_hit"}, 32'(hit_count), hc);
        check({tag, "_miss"}, 32'(miss_count), mc);
        check({tag, "_wb"}, 32'(wb_count), wc);
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        perf_clr  = 1'b0;
    endtask

    // kind: 0=hit, 1=clean miss, 2=dirty miss
    task automatic run_txn(input bit w, input bit both, input int kind,
                           input bit hw, input bit lru, input int wl,
                           input int fl, input bit clr);
        bit miss, dirty, way;
        int nwb, nfl, ncyc, last_wb, last_fl;
        logic rsp, pr, pw, ra, wa, ll, ds, dys, ps;
        logic v0, v1, t0, t1, d0, d1;
        logic [1:0] w0, w1;
        miss    = (kind != 0);
        dirty   = (kind == 2);
        nwb     = dirty ? wl : 0;
        nfl     = miss ? fl : 0;
        ncyc    = miss ? 3 + nwb + nfl : 2;
        last_wb = 1 + nwb;
        last_fl = 1 + nwb + nfl;
        lru_out = lru;
        if (kind == 2) begin
            valid_bit = 1'b1;
            dirty_bit = 1'b1;
        end else if (kind == 1) begin
            valid_bit = 1'($urandom_range(0, 1));
            dirty_bit = valid_bit ? 1'b0 : 1'($urandom_range(0, 1));
        end else begin
            valid_bit = 1'($urandom_range(0, 1));
            dirty_bit = 1'($urandom_range(0, 1));
        end
        mem_write = w;
        mem_read  = !w || both;
        for (int c = 0; c < ncyc; c++) begin
            hit0 = 1'b0; hit1 = 1'b0; pmem_resp = 1'b0; perf_clr = 1'b0;
            rsp = 0; pr = 0; pw = 0; ra = 0; wa = 0; ll = 0; ds = 0;
            dys = 0; ps = 0; v0 = 0; v1 = 0; t0 = 0; t1 = 0; d0 = 0;
            d1 = 0; w0 = 2'd0; w1 = 2'd0;
            if ((c == 1 && !miss) || (miss && c == ncyc - 1)) begin
                way = miss ? lru : hw;
                if (way) hit1 = 1'b1;
                else hit0 = 1'b1;
                if (!miss) perf_clr = clr;
                rsp = 1; ll = 1;
                if (w) begin
                    dys = 1;
                    if (way) begin w1 = 2'd1; d1 = 1; end
                    else begin w0 = 2'd1; d0 = 1; end
                end
            end else if (c == 0) begin
                ra = !w;
                wa = w;
            end else if (c >= 2 && c <= last_wb) begin
                pw = 1;
                if (c == last_wb) begin
                    pmem_resp = 1'b1;
                    if (lru) d1 = 1;
                    else d0 = 1;
                end
            end else if (c >= 2 && c <= last_fl) begin
                pr = 1; ps = 1; ds = 1;
                if (c == last_fl) begin
                    pmem_resp = 1'b1;
                    if (lru) begin w1 = 2'd2; t1 = 1; v1 = 1; d1 = 1; end
                    else begin w0 = 2'd2; t0 = 1; v0 = 1; d0 = 1; end
                end
            end
            @(negedge clk);
            check($sformatf("k%0d_cyc%0d", kind, c), 32'(obs),
                  32'({rsp, pr, pw, ra, wa, ll, ds, dys, ps,
                       w0, w1, v0, v1, t0, t1, d0, d1}));
            @(posedge clk);
            #1;
        end
        if (clr) begin
            hc = 0; mc = 0; wc = 0;
        end else if (!miss) begin
            hc = sat_inc(hc);
        end else begin
            mc = sat_inc(mc);
            if (dirty) wc = sat_inc(wc);
        end
        idle_inputs();
        @(negedge clk);
        check("idle", 32'(obs), 32'd0);
        check_cnt("cnt");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        valid_bit = 1'b0;
        dirty_bit = 1'b0;
        lru_out   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(obs), 32'd0);
        check_cnt("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // read hit way0, write hit way1, clean miss, dirty miss
        run_txn(1'b0, 1'b0, 0, 1'b0, 1'b0, 1, 1, 1'b0);
        run_txn(1'b1, 1'b0, 0, 1'b1, 1'b0, 1, 1, 1'b0);
        run_txn(1'b0, 1'b0, 1, 1'b0, 1'b0, 1, 5, 1'b0);
        run_txn(1'b1, 1'b0, 2, 1'b0, 1'b1, 3, 4, 1'b0);
        // both requests high: write wins
        run_txn(1'b1, 1'b1, 0, 1'b0, 1'b0, 1, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(1, 6)),
                    int'($urandom_range(1, 6)), 1'b0);
        end

        // reset while a writeback is in flight
        mem_write = 1'b1; valid_bit = 1'b1; dirty_bit = 1'b1; lru_out = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("wb_pmem_write", 32'(pmem_write), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_wb", 32'(obs), 32'd0);
        hc = 0; mc = 0; wc = 0;
        check_cnt("rst_mid_wb");
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst", 32'(obs), 32'd0);
        @(posedge clk);
        #1;

        // drive hit_count into saturation
        for (int i = 0; i < 18; i++)
            run_txn(1'($urandom_range(0, 1)), 1'b0, 0,
                    1'($urandom_range(0, 1)), 1'b0, 1, 1, 1'b0);
        check("hit_sat", 32'(hit_count), 32'd15);
        // clear coinciding with a hit
        run_txn(1'b0, 1'b0, 0, 1'b0, 1'b0, 1, 1, 1'b1);

        // request dropped before COMPARE
        mem_read = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        hit0 = 1'b1;
        @(negedge clk);
        check("drop_cmp", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        hit0 = 1'b0;
        @(negedge clk);
        check("drop_idle", 32'(obs), 32'd0);
        check_cnt("drop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
